toggle_handshake_tx: RTL and testbench

Source-side transmitter of a two-phase (toggle) request/acknowledge handshake carrying a data word across a clock-domain boundary. It accepts a word on a valid/ready interface and holds it stable on `xfer_data`. It flips `req_toggle` toward the destination domain and waits for the destination's returned `ack_toggle`, which it synchronizes internally, to match. It then reports completion. A timeout watchdog flags a missing acknowledge.

---
 rtl/toggle_handshake_if.sv | 35 +++
 rtl/toggle_handshake_tx.sv | 108 ++++++++++
 tb/tb_toggle_handshake_tx.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toggle_handshake_if.sv
// Bundle of the toggle-handshake transmitter's data-path and handshake signals.
//   slave  : seen by toggle_handshake_tx (accepts words, drives req/xfer, reads ack)
//   master : seen by the upstream producer / destination side
// Signals:
//   in_valid/in_data/in_ready : upstream valid/ready word interface
//   req_toggle/xfer_data      : request toggle and held word toward destination
//   ack_toggle                : asynchronous acknowledge toggle from destination
//   busy/done_pulse           : status and one-cycle completion pulse
//   timeout_err/err_clr       : sticky watchdog error and its clear
//   xfer_count                : completed-transfer counter (wraps)
interface toggle_handshake_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              req_toggle;
  logic [DATA_W-1:0] xfer_data;
  logic              ack_toggle;
  logic              busy;
  logic              done_pulse;
  logic              timeout_err;
  logic              err_clr;
  logic [15:0]       xfer_count;

  modport slave (
    input  in_valid, in_data, ack_toggle, err_clr,
    output in_ready, req_toggle, xfer_data, busy, done_pulse, timeout_err, xfer_count
  );

  modport master (
    output in_valid, in_data, ack_toggle, err_clr,
    input  in_ready, req_toggle, xfer_data, busy, done_pulse, timeout_err, xfer_count
  );
endinterface

// File: rtl/toggle_handshake_tx.sv
// Source-side transmitter of a two-phase (toggle) req/ack handshake.
// A word accepted on the valid/ready side is held on xfer_data while
// req_toggle is flipped; completion is declared once the synchronized
// ack_toggle equals req_toggle again. A watchdog parks the block in an
// error state if the acknowledge does not arrive in time.
// Ports:
//   clk_src : source clock, all logic on its rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : toggle_handshake_if.slave (see interface file for signal list)
module toggle_handshake_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk_src,
  input  logic                rst_n,
  toggle_handshake_if.slave   bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
  localparam logic [1:0] ERR      = 2'd2;

  // A zero-width timer is illegal, so a disabled watchdog still gets one bit.
  localparam int TMR_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_sync;
  logic                   match;
  logic                   req_q;
  logic [DATA_W-1:0]      data_q;
  logic                   done_q;
  logic                   err_q;
  logic [15:0]            count_q;
  logic [TMR_W-1:0]       timer_q;

  // ---- ack_toggle synchronizer: the only path from the destination domain
  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.ack_toggle};
    end
  end

  assign ack_sync = ack_sync_q[SYNC_STAGES-1];
  assign match    = (ack_sync == req_q);

  // ---- control state, held word and status registers
  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
      timer_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          // in_ready is high throughout IDLE, so valid alone means accept.
          if (bus.in_valid) begin
            data_q  <= bus.in_data;
            req_q   <= ~req_q;
            timer_q <= '0;
            state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // A match wins over an expiring timer on the same edge.
          if (match) begin
            done_q  <= 1'b1;
            count_q <= count_q + 16'd1;
            state   <= IDLE;
          end else if (TIMEOUT_CYC != 0 && timer_q == TMR_LAST) begin
            err_q <= 1'b1;
            state <= ERR;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        ERR: begin
          // Stay here even if the ack has since arrived; software must clear.
          if (bus.err_clr) begin
            err_q   <= 1'b0;
            timer_q <= '0;
            state   <= WAIT_ACK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.req_toggle  = req_q;
  assign bus.xfer_data   = data_q;
  assign bus.done_pulse  = done_q;
  assign bus.timeout_err = err_q;
  assign bus.xfer_count  = count_q;

endmodule

// File: tb/tb_toggle_handshake_tx.sv
module tb_toggle_handshake_tx;

  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int TMO  = 16;

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_ERR  = 2;

  logic clk;
  logic rst_n;
  logic loop_en;
  logic ack_drv;

  int n_chk;
  int n_fail;

  toggle_handshake_if #(.DATA_W(DW)) bus ();

  assign bus.ack_toggle = loop_en ? bus.req_toggle : ack_drv;

  toggle_handshake_tx #(
    .DATA_W(DW),
    .SYNC_STAGES(SYNC),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_src(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: edges are numbered, the acknowledge seen by the
  // block is the ack sampled SYNC edges earlier, and the watchdog is a
  // deadline edge number fixed when waiting starts.
  int          m_phase;
  logic        m_req;
  logic [DW-1:0] m_data;
  logic        m_done;
  logic        m_err;
  logic [15:0] m_count;
  int          m_edge;
  int          m_deadline;
  logic        ack_hist [64];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase    = P_IDLE;
      m_req      = 1'b0;
      m_data     = '0;
      m_done     = 1'b0;
      m_err      = 1'b0;
      m_count    = '0;
      m_edge     = 0;
      m_deadline = 0;
      for (int i = 0; i < 64; i++) ack_hist[i] = 1'b0;
    end else begin
      logic a_seen;
      logic a_now;
      a_seen = ack_hist[(m_edge + 64 - SYNC) % 64];
      a_now  = loop_en ? m_req : ack_drv;
      m_done = 1'b0;
      case (m_phase)
        P_IDLE: begin
          if (bus.in_valid) begin
            m_data     = bus.in_data;
            m_req      = ~m_req;
            m_deadline = m_edge + TMO;
            m_phase    = P_WAIT;
          end
        end
        P_WAIT: begin
          if (a_seen == m_req) begin
            m_done  = 1'b1;
            m_count = m_count + 16'd1;
            m_phase = P_IDLE;
          end else if (m_edge == m_deadline) begin
            m_err   = 1'b1;
            m_phase = P_ERR;
          end
        end
        default: begin
          if (bus.err_clr) begin
            m_err      = 1'b0;
            m_deadline = m_edge + TMO;
            m_phase    = P_WAIT;
          end
        end
      endcase
      ack_hist[m_edge % 64] = a_now;
      m_edge++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    @(negedge clk);
    chk("model in_ready",    bus.in_ready,    (m_phase == P_IDLE));
    chk("model busy",        bus.busy,        (m_phase != P_IDLE));
    chk("model req_toggle",  bus.req_toggle,  m_req);
    chk("model xfer_data",   bus.xfer_data,   m_data);
    chk("model done_pulse",  bus.done_pulse,  m_done);
    chk("model timeout_err", bus.timeout_err, m_err);
    chk("model xfer_count",  bus.xfer_count,  m_count);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int ack_delay;
    n_chk   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    loop_en = 1'b0;
    ack_drv = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.err_clr  = 1'b0;

    // Reset state
    ticks(3);
    chk("rst in_ready", bus.in_ready, 1);
    chk("rst busy", bus.busy, 0);
    chk("rst xfer_count", bus.xfer_count, 0);
    rst_n = 1'b1;
    tick();

    // Loopback: 0xA5 then 0x3C with valid held high, busy-input immunity
    loop_en = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    tick();                                   // after edge N
    chk("lb accept req", bus.req_toggle, 1);
    chk("lb accept data", bus.xfer_data, 8'hA5);
    chk("lb accept in_ready", bus.in_ready, 0);
    chk("lb accept busy", bus.busy, 1);
    tick();                                   // after N+1
    bus.in_data = 8'hFF;
    tick();                                   // after N+2
    chk("immune data", bus.xfer_data, 8'hA5);
    chk("immune req", bus.req_toggle, 1);
    chk("lb done N+2", bus.done_pulse, 0);
    bus.in_data = 8'h3C;
    tick();                                   // after N+3
    chk("lb done N+3", bus.done_pulse, 1);
    chk("lb count1", bus.xfer_count, 1);
    chk("lb data held", bus.xfer_data, 8'hA5);
    tick();                                   // after N+4
    bus.in_valid = 1'b0;
    chk("lb 2nd req", bus.req_toggle, 0);
    chk("lb 2nd data", bus.xfer_data, 8'h3C);
    ticks(2);                                 // after N+6
    chk("lb done N+6", bus.done_pulse, 0);
    tick();                                   // after N+7
    chk("lb done N+7", bus.done_pulse, 1);
    chk("lb count2", bus.xfer_count, 2);
    tick();

    // Asynchronous reset mid-cycle takes effect immediately
    #2;
    rst_n = 1'b0;
    #1;
    chk("async in_ready", bus.in_ready, 1);
    chk("async req", bus.req_toggle, 0);
    chk("async data", bus.xfer_data, 8'h00);
    chk("async busy", bus.busy, 0);
    chk("async done", bus.done_pulse, 0);
    chk("async err", bus.timeout_err, 0);
    chk("async count", bus.xfer_count, 0);
    tick();
    rst_n = 1'b1;
    loop_en = 1'b0;
    ack_drv = 1'b0;
    tick();

    // Timeout and recovery, ack held 0
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    tick();                                   // after accept edge N
    bus.in_valid = 1'b0;
    ticks(15);                                // after N+15
    chk("tmo err N+15", bus.timeout_err, 0);
    tick();                                   // after N+16
    chk("tmo err N+16", bus.timeout_err, 1);
    chk("tmo in_ready", bus.in_ready, 0);
    ack_drv = 1'b1;
    ticks(4);
    chk("tmo err sticky", bus.timeout_err, 1);
    chk("tmo busy", bus.busy, 1);
    chk("tmo no done", bus.done_pulse, 0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("clr err", bus.timeout_err, 0);
    chk("clr busy", bus.busy, 1);
    chk("clr done", bus.done_pulse, 0);
    tick();
    chk("late done", bus.done_pulse, 1);
    chk("late count", bus.xfer_count, 1);

    // Race: match arrives on the timeout edge
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC3;
    tick();                                   // after N, req -> 0
    bus.in_valid = 1'b0;
    ticks(13);                                // after N+13
    ack_drv = 1'b0;
    ticks(2);                                 // after N+15
    chk("race done N+15", bus.done_pulse, 0);
    chk("race err N+15", bus.timeout_err, 0);
    tick();                                   // after N+16
    chk("race done", bus.done_pulse, 1);
    chk("race err", bus.timeout_err, 0);
    chk("race in_ready", bus.in_ready, 1);
    chk("race count", bus.xfer_count, 2);

    // Reset mid-flight
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    tick();
    bus.in_valid = 1'b0;
    ticks(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mf req", bus.req_toggle, 0);
    chk("mf done", bus.done_pulse, 0);
    chk("mf count", bus.xfer_count, 0);
    chk("mf busy", bus.busy, 0);
    tick();
    rst_n = 1'b1;
    loop_en = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    tick();                                   // after N
    bus.in_valid = 1'b0;
    ticks(3);                                 // after N+3
    chk("mf after done", bus.done_pulse, 1);
    chk("mf after count", bus.xfer_count, 1);
    chk("mf after data", bus.xfer_data, 8'h5A);

    // Randomized traffic with a random-latency destination
    loop_en   = 1'b0;
    ack_drv   = bus.req_toggle;
    ack_delay = -1;
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid = ($urandom_range(0, 1) == 1);
      bus.in_data  = DW'($urandom);
      bus.err_clr  = bus.timeout_err ? ($urandom_range(0, 3) == 0)
                                     : ($urandom_range(0, 7) == 0);
      if (ack_drv != bus.req_toggle) begin
        if (ack_delay < 0) begin
          ack_delay = $urandom_range(0, 24);
        end else if (ack_delay == 0) begin
          ack_drv   = bus.req_toggle;
          ack_delay = -1;
        end else begin
          ack_delay--;
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.err_clr  = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
